// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants for the timing generator and the
// background, sprite and overlay pixel generators.
//   Default mode: 640x480 at 60 Hz, 25 MHz pixel rate.
//   Counts start at 0 on the first cycle of sync. Each line and each frame
//   runs sync, back porch, active, then front porch.
package vga_pkg;

    localparam int COUNT_W  = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;   // 800
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;   // 525
    localparam int H_START  = H_SYNC + H_BP;                     // 144
    localparam int V_START  = V_SYNC + V_BP;                     // 35

    localparam int TILE_SHIFT = 5;
    localparam int TILE_COLS  = 20;
    localparam int TILE_ROWS  = 15;

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// wrap_counter: modulo-MODULUS up-counter.
//   clk, rst : clock, asynchronous active-high reset
//   ce       : clock enable
//   inc      : advance request, honoured only when ce is high
//   count    : current value, 0..MODULUS-1
//   wrap     : combinational, high when this advance takes count back to 0
module wrap_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic step;

    assign step = ce & inc;
    assign wrap = step && (count == WIDTH'(MODULUS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the shared h_count/v_count bus
// and the VGA sync pins.
//   clk, rst    : clock, asynchronous active-high reset
//   ce          : pixel clock enable
//   h_count     : horizontal position, 0..H_TOTAL-1
//   v_count     : vertical position, 0..V_TOTAL-1
//   hsync/vsync : active-low sync pulses
//   active      : inside the visible window
//   line_start  : one-cycle pulse when h_count has just entered 0
//   frame_start : one-cycle pulse when both counts have just entered 0
//   tile_col/tile_row : 32-px tile coordinates, all-ones outside the window.
//                 Present only with VGA_TILE_COORD_EN defined; otherwise
//                 they are tied to 0.
// The flags are registered from the next count values, so they always
// describe the counts shown in the same cycle.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [4:0]         tile_col,
    output logic [3:0]         tile_row
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [COUNT_W-1:0] H_SYNC_C  = COUNT_W'(H_SYNC);
    localparam logic [COUNT_W-1:0] V_SYNC_C  = COUNT_W'(V_SYNC);
    localparam logic [COUNT_W-1:0] H_START_C = COUNT_W'(H_SYNC + H_BP);
    localparam logic [COUNT_W-1:0] V_START_C = COUNT_W'(V_SYNC + V_BP);
    localparam logic [COUNT_W-1:0] H_END_C   = COUNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_END_C   = COUNT_W'(V_SYNC + V_BP + V_ACTIVE);

    if (H_TOTAL > (1 << COUNT_W) || V_TOTAL > (1 << COUNT_W)) begin : g_bad_timing
        $error("vga_timing: H_TOTAL=%0d or V_TOTAL=%0d exceeds 10-bit counters",
               H_TOTAL, V_TOTAL);
    end

    logic               h_wrap;
    logic               v_wrap;
    logic [COUNT_W-1:0] h_nxt;
    logic [COUNT_W-1:0] v_nxt;
    logic               act_nxt;

    wrap_counter #(.MODULUS(H_TOTAL), .WIDTH(COUNT_W)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .inc   (1'b1),
        .count (h_count),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MODULUS(V_TOTAL), .WIDTH(COUNT_W)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .inc   (h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    // Next count values, used only to precompute the registered flags.
    always_comb begin
        h_nxt = h_count;
        v_nxt = v_count;
        if (ce) begin
            h_nxt = h_wrap ? '0 : h_count + COUNT_W'(1);
            if (h_wrap) begin
                v_nxt = v_wrap ? '0 : v_count + COUNT_W'(1);
            end
        end
    end

    assign act_nxt = (h_nxt >= H_START_C) && (h_nxt < H_END_C) &&
                     (v_nxt >= V_START_C) && (v_nxt < V_END_C);

    // v_wrap can only fire together with h_wrap, so frame_start implies line_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hsync       <= (h_nxt >= H_SYNC_C);
            vsync       <= (v_nxt >= V_SYNC_C);
            active      <= act_nxt;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TILE_COORD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_col <= '0;
            tile_row <= '0;
        end else if (ce) begin
            tile_col <= act_nxt ? 5'((h_nxt - H_START_C) >> TILE_SHIFT) : 5'h1F;
            tile_row <= act_nxt ? 4'((v_nxt - V_START_C) >> TILE_SHIFT) : 4'hF;
        end
    end
`else
    assign tile_col = '0;
    assign tile_row = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing. Two instances share clk/rst/ce: the default
// 640x480 mode, and a tiny mode (25x11 totals) so that full frames fit in
// a short run. Each cycle both are compared against a model that works
// from the number of enabled edges since reset.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    always #5 clk = ~clk;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [4:0] d_tc, s_tc;
    logic [3:0] d_tr, s_tr;

    vga_timing dut (
        .clk(clk), .rst(rst), .ce(ce),
        .h_count(d_h), .v_count(d_v), .hsync(d_hs), .vsync(d_vs),
        .active(d_act), .line_start(d_ls), .frame_start(d_fs),
        .tile_col(d_tc), .tile_row(d_tr)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .rst(rst), .ce(ce),
        .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
        .active(s_act), .line_start(s_ls), .frame_start(s_fs),
        .tile_col(s_tc), .tile_row(s_tr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model state: enabled edges since reset, whether any happened yet,
    // and whether the most recent edge was enabled.
    int n;
    bit fresh;
    bit last_ce;

    function automatic logic [63:0] pack(input int h, input int v, input bit hs, input bit vs,
                                         input bit a, input bit ls, input bit fs,
                                         input logic [4:0] tc, input logic [3:0] tr);
        return 64'({tr, tc, fs, ls, a, vs, hs, 10'(v), 10'(h)});
    endfunction

    function automatic logic [63:0] model(input int htot, input int vtot, input int hsw,
                                          input int vsw, input int hst, input int vst,
                                          input int hact, input int vact);
        int h, v;
        bit a, ls, fs;
        logic [4:0] tc;
        logic [3:0] tr;
        if (fresh) return pack(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        h  = n % htot;
        v  = (n / htot) % vtot;
        a  = (h >= hst) && (h < hst + hact) && (v >= vst) && (v < vst + vact);
        ls = last_ce && (h == 0);
        fs = ls && (v == 0);
`ifdef VGA_TILE_COORD_EN
        tc = a ? 5'((h - hst) / 32) : 5'h1F;
        tr = a ? 4'((v - vst) / 32) : 4'hF;
`else
        tc = 5'd0;
        tr = 4'd0;
`endif
        return pack(h, v, !(h < hsw), !(v < vsw), a, ls, fs, tc, tr);
    endfunction

    function automatic logic [63:0] exp_d();
        return model(800, 525, 96, 2, 144, 35, 640, 480);
    endfunction

    function automatic logic [63:0] exp_s();
        return model(25, 11, 4, 2, 7, 4, 16, 6);
    endfunction

    function automatic logic [63:0] got_d();
        return pack(int'(d_h), int'(d_v), d_hs, d_vs, d_act, d_ls, d_fs, d_tc, d_tr);
    endfunction

    function automatic logic [63:0] got_s();
        return pack(int'(s_h), int'(s_v), s_hs, s_vs, s_act, s_ls, s_fs, s_tc, s_tr);
    endfunction

    task automatic check_both(input string tag);
        check({tag, "_dflt"}, got_d(), exp_d());
        check({tag, "_small"}, got_s(), exp_s());
    endtask

    // Called at a negedge: drive ce, take one edge, update model, check.
    task automatic cycle(input bit ce_val, input string tag);
        ce = ce_val;
        @(posedge clk);
        if (ce_val) begin
            n++;
            fresh   = 1'b0;
            last_ce = 1'b1;
        end else begin
            last_ce = 1'b0;
        end
        @(negedge clk);
        check_both(tag);
    endtask

    task automatic model_reset();
        n       = 0;
        fresh   = 1'b1;
        last_ce = 1'b0;
    endtask

    int cyc;
    int prev_fs;
    int prev_ls;
    int act_cnt;

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_both("reset");
        rst = 1'b0;
        cycle(1'b0, "post_rel");

        // Continuous ce: frame/line period and active count per small frame.
        prev_fs = -1;
        prev_ls = -1;
        act_cnt = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            cycle(1'b1, "run");
            if (s_fs) begin
                if (prev_fs >= 0) begin
                    check("frame_period_small", 64'(cyc - prev_fs), 64'd275);
                    check("active_per_frame_small", 64'(act_cnt), 64'd96);
                end
                prev_fs = cyc;
                act_cnt = 0;
            end
            if (s_act) act_cnt++;
            if (d_ls) begin
                if (prev_ls >= 0) check("line_period_dflt", 64'(cyc - prev_ls), 64'd800);
                prev_ls = cyc;
            end
        end

        // ce pattern 1,0,0,1 across the default line wrap.
        for (int i = 0; i < 800 && (n % 800) != 799; i++) cycle(1'b1, "align");
        cycle(1'b1, "wrap_ce1");
        check("ls_launch", 64'(d_ls), 64'd1);
        cycle(1'b0, "wrap_ce0a");
        check("ls_one_cycle", 64'(d_ls), 64'd0);
        cycle(1'b0, "wrap_ce0b");
        cycle(1'b1, "wrap_ce1b");

        // Random ce; long enough for the default instance to reach v=35.
        for (int i = 0; i < 36000; i++) cycle($urandom_range(0, 9) != 0, "rand");

        // Asynchronous reset between edges.
        ce = 1'b1;
        @(posedge clk);
        n++;
        fresh   = 1'b0;
        last_ce = 1'b1;
        #2 rst = 1'b1;
        #1 model_reset();
        check_both("async_rst");
        @(negedge clk);
        check_both("rst_hold");
        ce  = 1'b0;
        rst = 1'b0;
        cycle(1'b0, "post_rel2");
        for (int i = 0; i < 1000; i++) cycle(1'b1, "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator that drives the shared h_count/v_count bus used by the background, sprite and overlay pixel generators, plus the VGA sync pins.
- Default mode is 640x480 at 60 Hz, one pixel per enabled clock (25 MHz pixel rate).
- Count origin 0 is the first cycle of the sync pulse. Each line runs sync, back porch, active, front porch, so active video starts at h=144 and v=35.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  pixel clock enable; tie high when clk equals the pixel rate
- h_count  out  10  horizontal position, 0..H_TOTAL-1
- v_count  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- active  out  1  high inside the visible window
- line_start  out  1  one-cycle pulse when h_count enters 0
- frame_start  out  1  one-cycle pulse when h_count and v_count both enter 0
- tile_col  out  5  32-px tile column (optional feature)
- tile_row  out  4  32-px tile row (optional feature)

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Derived values:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 800; V_TOTAL = 525.
  - H_START = H_SYNC+H_BP = 144; V_START = V_SYNC+V_BP = 35.
- Reset values: h_count=0, v_count=0, hsync=1, vsync=1, active=0, line_start=0, frame_start=0, tile_col=0, tile_row=0. Asynchronous assertion mid-frame forces these values immediately.
- Counting, on a clk edge with ce=1:
  - h_count increments.
  - At h_count=H_TOTAL-1 it wraps to 0 and v_count increments.
  - At v_count=V_TOTAL-1 together with h_count=H_TOTAL-1, both wrap to 0.
- ce=0: every register holds its value, except line_start and frame_start, which clear.
- All outputs are registered and computed from the next count values. On every cycle they describe the h_count/v_count presented in that same cycle, with zero skew between counts and flags. Consumers may decode the counts combinationally.
- Sync decoding:
  - hsync=0 iff h_count < H_SYNC.
  - vsync=0 iff v_count < V_SYNC.
- Active window: active=1 iff H_START ≤ h_count < H_START+H_ACTIVE and V_START ≤ v_count < V_START+V_ACTIVE (h 144..783, v 35..514).
- Pulses:
  - line_start is high for exactly the one cycle following a ce edge that moved h_count to 0.
  - frame_start is the same, for both counts reaching 0. frame_start implies line_start.
- First cycle after reset release: counts are 0 with sync still deasserted. The first ce edge moves to h=1 with hsync=0. No pulses fire for the reset-time origin.
- Counter widths: 10 bits each. Any parameter set with H_TOTAL or V_TOTAL > 1024 is illegal; flag this in an elaboration check.

Optional Feature:
- Macro: VGA_TILE_COORD_EN.
- Defined:
  - tile_col = (h_count-H_START)>>5 and tile_row = (v_count-V_START)>>5, registered and aligned with the counts like the other flags.
  - Ranges are 0..19 and 0..14 when active=1.
  - Both read all-ones (5'h1F, 4'hF) when active=0.
- Undefined: tile_col and tile_row are constant 0 and the subtract/shift logic is absent. The ports stay present so instantiations do not change.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_*, V_*);
  - derived H_TOTAL, V_TOTAL, H_START, V_START;
  - TILE_SHIFT=5, TILE_COLS=20, TILE_ROWS=15.
  These are shared with the pixel generators.
- One sub-module: wrap_counter (parameterised modulus and width, inputs ce and inc, outputs count and wrap). It is instantiated twice, with the horizontal wrap driving the vertical inc.

Test Plan:
- Reset, release, ce=1 for 420000 cycles: frame_start period is exactly 420000 cycles; line_start period is 800 cycles.
- hsync low exactly on h_count 0..95 and vsync low exactly on v_count 0..1. Check transitions at h 95→96 and v 1→2, both in the same cycle as the count change.
- active rises on the cycle with h=144, v=35 and falls at h=784. It is never high for v ≥ 515 or v < 35. 640×480 = 307200 active cycles per frame.
- ce toggled 1,0,0,1: counts advance only on ce cycles. A line_start pulse launched at h=0 lasts exactly one cycle even though ce=0 follows.
- Assert rst asynchronously at h=500, v=200, between clk edges: outputs reach reset values before the next edge. After release, counting restarts from 0 with no spurious pulse.
- VGA_TILE_COORD_EN defined: at h=144, v=35, tile_col=0, tile_row=0; at h=783, v=514, tile_col=19, tile_row=14; at h=100, tile_col=5'h1F, tile_row=4'hF.
